// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side signal bundle: address/control from the bus, response back to it.
// Latency: none (wires only).
// Backpressure: the slave stalls the bus through HREADY.
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic [1:0]            HRESP;
    logic                  HSPLIT;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP, HSPLIT
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP, HSPLIT
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: flop-array memory with programmable wait states and two-cycle ERROR.
// Latency: OKAY data phase WAIT_STATES+1 cycles, ERROR exactly 2 cycles; fully pipelined.
// Backpressure: HREADY low during wait states and ERR1. Optional macro AHB_SLV_PROT_CHECK_EN.
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_sram_slave_if.slave    bus
);

    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [3:0]            WS        = 4'(WAIT_STATES);
    localparam logic [1:0]            RESP_OKAY = 2'b00;
    localparam logic [1:0]            RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_pend;   // an accepted OKAY transfer is in its data phase
    logic                  r_write;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    state_t                w_state_nxt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_pend_nxt;
    logic                  w_hready;
    logic [1:0]            w_hresp;
    logic                  w_accept;

    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_range_err;
    logic                  w_size_err;
    logic                  w_align_err;
    logic                  w_prot_err;
    logic                  w_xfer_err;
    logic [IDX_W-1:0]      w_idx_in;
    logic [3:0]            w_be_in;
    logic                  w_done;
    logic                  w_wr_done;
    logic                  w_rd_done;

    // Address-phase decode: offset into the array and the three error classes
    assign w_off       = bus.HADDR - BASE_ADDR;
    assign w_range_err = (bus.HADDR < BASE_ADDR) || (w_off >= MEM_BYTES);
    assign w_size_err  = (bus.HSIZE > 3'd2);
    assign w_align_err = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                         ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
    assign w_idx_in    = w_off[IDX_W+1:2];

`ifdef AHB_SLV_PROT_CHECK_EN
    // User-mode writes may not touch the upper half of the array
    assign w_prot_err  = bus.HWRITE && !bus.HPROT[1] && w_idx_in[IDX_W-1];
`else
    assign w_prot_err  = 1'b0;
`endif

    assign w_xfer_err  = w_range_err || w_size_err || w_align_err || w_prot_err;

    // Byte-lane enables derived from size and low address bits at capture time
    always_comb begin
        w_be_in = 4'b0000;
        case (bus.HSIZE)
            3'd0:    w_be_in = 4'b0001 << bus.HADDR[1:0];
            3'd1:    w_be_in = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be_in = 4'b1111;
            default: w_be_in = 4'b0000;
        endcase
    end

    // Next-state and response outputs; any cycle with HREADY high may accept a new address
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_hready    = 1'b1;
        w_hresp     = RESP_OKAY;
        w_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_hready = 1'b1;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_hready = 1'b1;
                end else begin
                    w_hready  = 1'b0;
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ERR1: begin
                w_hready    = 1'b0;
                w_hresp     = RESP_ERR;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                w_hready = 1'b1;
                w_hresp  = RESP_ERR;
            end
            default: begin
                w_hready    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_hready) begin
            w_accept = bus.HSEL && bus.HTRANS[1];
            if (!w_accept) begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = 1'b0;
            end else if (w_xfer_err) begin
                w_state_nxt = S_ERR1;
                w_pend_nxt  = 1'b0;
            end else if (WS == 4'd0) begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = WS;
                w_pend_nxt  = 1'b1;
            end
        end
    end

    // State register plus capture of the accepted address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_pend  <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_be    <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            if (w_accept && !w_xfer_err) begin
                r_write <= bus.HWRITE;
                r_idx   <= w_idx_in;
                r_be    <= w_be_in;
            end
        end
    end

    assign w_done    = r_pend && w_hready;
    assign w_wr_done = w_done && r_write;
    assign w_rd_done = w_done && !r_write;

    // Array write on the edge ending a write data phase; contents survive reset
    always_ff @(posedge HCLK) begin
        if (w_wr_done) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HRDATA = w_rd_done ? r_mem[r_idx] : '0;
    assign bus.HREADY = w_hready;
    assign bus.HRESP  = w_hresp;
    assign bus.HSPLIT = 1'b0;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB responder (slave end of the team's AHB bus): a flop-array memory with programmable wait states and ERROR responses.
- Sits behind the address decoder on one HSEL line and presents the slave-side signal set (HRDATA, HREADY, HRESP, HSPLIT) back to the bus.
- Serves as the bus-level target for master driver and arbiter verification.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- MEM_DEPTH, 256, number of 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_DEPTH*4.
- WAIT_STATES, 0, cycles of HREADY=0 inserted per OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock, rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  decoder select for this slave.
- HADDR  in  ADDR_WIDTH  address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HBURST  in  3  burst type; ignored (each beat carries its own address).
- HPROT  in  4  protection; used only with the optional feature.
- HWDATA  in  DATA_WIDTH  write data.
- HRDATA  out  DATA_WIDTH  read data.
- HREADY  out  1  transfer done / wait control; this slave's HREADY is the bus HREADY.
- HRESP  out  2  OKAY=00, ERROR=01; RETRY and SPLIT are never issued.
- HSPLIT  out  1  tied 0.

Behaviour:
- Reset (async assert, sync deassert at HCLK):
  - HREADY=1, HRESP=00, HRDATA=0, HSPLIT=0, state=IDLE.
  - Memory contents are not reset.
  - Reset mid-transfer abandons the transfer; no memory write occurs.
- Address phase accepted on a rising edge when HSEL && HREADY && HTRANS[1].
  - Capture HADDR, HWRITE, HSIZE (and HPROT when the optional feature is compiled in).
  - IDLE or BUSY transfers, and cycles with HSEL=0, give a zero-wait OKAY and cause no access.
- Error check at capture: any one of the following gives ERROR.
  - Out of range: (HADDR - BASE_ADDR) >= MEM_DEPTH*4, or HADDR < BASE_ADDR.
  - Bad size: HSIZE > 2.
  - Misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADY=1, HRESP=OKAY.
    - Valid accept with WAIT_STATES=0: stay in IDLE; the next cycle is the completing data phase.
    - Valid accept with WAIT_STATES>0: go to WAIT, wait counter = WAIT_STATES.
    - Accept with an error condition: go to ERR1.
  - WAIT: HREADY=0, HRESP=OKAY; counter decrements each cycle. At 0, the data phase completes with HREADY=1 and the FSM follows the IDLE accept rules for any new address phase.
  - ERR1: HREADY=0, HRESP=01; always goes to ERR2.
  - ERR2: HREADY=1, HRESP=01. A new address phase may be accepted here; it is evaluated with the IDLE rules.
- Latency:
  - OKAY transfer: WAIT_STATES+1 data-phase cycles.
  - ERROR transfer: exactly 2 cycles.
  - Back-to-back transfers pipeline fully: the next address is captured on the same edge that completes the current data phase.
- Reads:
  - HRDATA is driven combinationally from mem[(addr-BASE_ADDR)>>2] during the completing read data-phase cycle.
  - The full word is returned regardless of HSIZE.
  - HRDATA=0 in all other cycles, including ERROR.
- Writes: HWDATA is sampled on the edge ending the completing data phase, with byte enables as follows.
  - HSIZE=0: byte lane addr[1:0].
  - HSIZE=1: lanes {addr[1],1'b0}+:2.
  - HSIZE=2: all 4 lanes.
- ERROR responses never modify memory.
- Write followed immediately by a read of the same word returns the new data; this holds naturally because the array is written before the read data phase.
- Address wrap: only index bits [log2(MEM_DEPTH)+1:2] are used after the range check. There is no aliasing.

Optional Feature:
- Macro: AHB_SLV_PROT_CHECK_EN.
- Defined: a write with HPROT[1]=0 (user access) to the upper half of memory (index >= MEM_DEPTH/2) receives the two-cycle ERROR response and memory is unchanged. Reads are unaffected.
- Undefined: HPROT is ignored and there is no extra check logic.

Test Plan:
- Reset with HRESETn=0, then release → HREADY=1, HRESP=00, HRDATA=0, HSPLIT=0.
- WAIT_STATES=2: NONSEQ word write 0xDEADBEEF to BASE+0x10, then NONSEQ read of BASE+0x10 → each data phase shows HREADY=0,0,1; read returns 0xDEADBEEF.
- WAIT_STATES=0: write word 0x11223344 to 0x20, then byte write 0xAA on lane 3 at 0x23, then read 0x20 → 0xAA223344; each beat completes in 1 cycle.
- Write to BASE+MEM_DEPTH*4 → HRESP=01 with HREADY=0 for one cycle, then HRESP=01 with HREADY=1; a NONSEQ read of 0x0 issued during ERR2 completes with OKAY.
- Halfword access at 0x21, and a transfer with HSIZE=3 → both give the two-cycle ERROR; a subsequent read shows memory unchanged.
- With AHB_SLV_PROT_CHECK_EN: user write (HPROT=4'b0001) to index MEM_DEPTH-1 → ERROR; privileged write (HPROT=4'b0011) to the same index → OKAY, data stored.
